// File: rtl/mod_n_stream.sv
`default_nettype none
// ==== mod_n_stream : MSB-first digit-stream residue (value mod MOD) per framed packet ====
// ==== rev 1.0 ============================================================================
module mod_n_stream #(
  parameter int MOD     = 3,
  parameter int RES_W   = 2,
  parameter int DIGIT_W = 1,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               finish,
  input  logic               in_valid,
  input  logic [DIGIT_W-1:0] in_data,
  output logic               busy,
  output logic [RES_W-1:0]   residue,
  output logic               divisible,
  output logic               out_valid,
  output logic [CNT_W-1:0]   beat_cnt
);

  localparam logic [RES_W:0] c_mod = (RES_W+1)'(MOD);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [RES_W-1:0]  r_acc;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_load;
  logic              w_done;
  logic [RES_W-1:0]  w_base;
  logic [RES_W:0]    w_t;
  logic [RES_W-1:0]  w_acc_next;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic [CNT_W-1:0]  w_cnt_next;

  // A start always begins from an empty frame, even mid-frame.
  assign w_base     = start ? '0 : r_acc;
  assign w_cnt_base = start ? '0 : r_cnt;

  // Shift in one bit at a time; t < 2*MOD keeps a single conditional subtract exact.
  always_comb begin
    w_t = {1'b0, w_base};
    for (int i = DIGIT_W - 1; i >= 0; i--) begin
      w_t = {w_t[RES_W-1:0], in_data[i]};
      if (w_t >= c_mod) begin
        w_t = w_t - c_mod;
      end
    end
  end

  assign w_acc_next = in_valid ? w_t[RES_W-1:0] : w_base;
  assign w_cnt_inc  = (w_cnt_base == '1) ? w_cnt_base : w_cnt_base + 1'b1;
  assign w_cnt_next = in_valid ? w_cnt_inc : w_cnt_base;

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = ACC;
          w_load       = 1'b1;
        end
      end
      ACC: begin
        w_load = 1'b1;
        if (!start && finish) begin
          w_state_next = IDLE;
          w_done       = 1'b1;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_cnt     <= '0;
      residue   <= '0;
      divisible <= 1'b0;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      out_valid <= w_done;
      if (w_load) begin
        r_acc <= w_acc_next;
        r_cnt <= w_cnt_next;
      end
      if (w_done) begin
        residue   <= w_acc_next;
        divisible <= (w_acc_next == '0);
        beat_cnt  <= w_cnt_next;
      end
    end
  end

  assign busy = (r_state == ACC);

endmodule
`default_nettype wire

// File: tb/tb_mod_n_stream.sv
`default_nettype none
// ==== tb_mod_n_stream : directed + random frames on four parameterisations vs. reference ====
// ==== rev 1.0 ===============================================================================
module tb_mod_n_stream;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, finish, in_valid;
  logic [3:0] data;

  always #5 clk = ~clk;

  logic       busy_a, div_a, ov_a;  logic [1:0] res_a;  logic [7:0] cnt_a;
  logic       busy_b, div_b, ov_b;  logic [2:0] res_b;  logic [7:0] cnt_b;
  logic       busy_c, div_c, ov_c;  logic [2:0] res_c;  logic [7:0] cnt_c;
  logic       busy_d, div_d, ov_d;  logic [1:0] res_d;  logic [1:0] cnt_d;

  mod_n_stream #(.MOD(3), .RES_W(2), .DIGIT_W(1), .CNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
    .in_data(data[0:0]), .busy(busy_a), .residue(res_a), .divisible(div_a),
    .out_valid(ov_a), .beat_cnt(cnt_a));
  mod_n_stream #(.MOD(5), .RES_W(3), .DIGIT_W(4), .CNT_W(8)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
    .in_data(data[3:0]), .busy(busy_b), .residue(res_b), .divisible(div_b),
    .out_valid(ov_b), .beat_cnt(cnt_b));
  mod_n_stream #(.MOD(7), .RES_W(3), .DIGIT_W(2), .CNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
    .in_data(data[1:0]), .busy(busy_c), .residue(res_c), .divisible(div_c),
    .out_valid(ov_c), .beat_cnt(cnt_c));
  mod_n_stream #(.MOD(4), .RES_W(2), .DIGIT_W(3), .CNT_W(2)) u_d (
    .clk(clk), .rst_n(rst_n), .start(start), .finish(finish), .in_valid(in_valid),
    .in_data(data[2:0]), .busy(busy_d), .residue(res_d), .divisible(div_d),
    .out_valid(ov_d), .beat_cnt(cnt_d));

  // Reference model: digits of the open frame, evaluated as a number when it closes.
  int         vectors = 0;
  int         miscompares = 0;
  bit         open = 1'b0;
  bit         ov_exp = 1'b0;
  logic [3:0] q[$];
  int         last_res[4] = '{0, 0, 0, 0};
  int         last_cnt[4] = '{0, 0, 0, 0};
  bit         last_div[4] = '{0, 0, 0, 0};
  int         mods[4] = '{3, 5, 7, 4};
  int         dws[4]  = '{1, 4, 2, 3};
  int         cws[4]  = '{8, 8, 8, 2};

  function automatic int ref_res(int k);
    longint r = 0;
    foreach (q[j]) r = (r * (64'd1 << dws[k]) + (q[j] & ((1 << dws[k]) - 1))) % mods[k];
    return int'(r);
  endfunction

  function automatic int ref_cnt(int k);
    int sat = (1 << cws[k]) - 1;
    return (q.size() > sat) ? sat : q.size();
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(string ph);
    chk({ph, ".a.busy"}, 32'(busy_a), 32'(open));
    chk({ph, ".a.ov"},   32'(ov_a),   32'(ov_exp));
    chk({ph, ".a.res"},  32'(res_a),  last_res[0]);
    chk({ph, ".a.div"},  32'(div_a),  32'(last_div[0]));
    chk({ph, ".a.cnt"},  32'(cnt_a),  last_cnt[0]);
    chk({ph, ".b.busy"}, 32'(busy_b), 32'(open));
    chk({ph, ".b.ov"},   32'(ov_b),   32'(ov_exp));
    chk({ph, ".b.res"},  32'(res_b),  last_res[1]);
    chk({ph, ".b.div"},  32'(div_b),  32'(last_div[1]));
    chk({ph, ".b.cnt"},  32'(cnt_b),  last_cnt[1]);
    chk({ph, ".c.busy"}, 32'(busy_c), 32'(open));
    chk({ph, ".c.ov"},   32'(ov_c),   32'(ov_exp));
    chk({ph, ".c.res"},  32'(res_c),  last_res[2]);
    chk({ph, ".c.div"},  32'(div_c),  32'(last_div[2]));
    chk({ph, ".c.cnt"},  32'(cnt_c),  last_cnt[2]);
    chk({ph, ".d.busy"}, 32'(busy_d), 32'(open));
    chk({ph, ".d.ov"},   32'(ov_d),   32'(ov_exp));
    chk({ph, ".d.res"},  32'(res_d),  last_res[3]);
    chk({ph, ".d.div"},  32'(div_d),  32'(last_div[3]));
    chk({ph, ".d.cnt"},  32'(cnt_d),  last_cnt[3]);
  endtask

  task automatic beat(bit s, bit f, bit v, logic [3:0] d);
    start = s; finish = f; in_valid = v; data = d;
    @(posedge clk);
    ov_exp = 1'b0;
    if (s) begin
      open = 1'b1;
      q.delete();
      if (v) q.push_back(d);
    end else if (open) begin
      if (v) q.push_back(d);
      if (f) begin
        for (int k = 0; k < 4; k++) begin
          last_res[k] = ref_res(k);
          last_div[k] = (last_res[k] == 0);
          last_cnt[k] = ref_cnt(k);
        end
        open   = 1'b0;
        ov_exp = 1'b1;
      end
    end
    #1;
    check_all("beat");
    start = 1'b0; finish = 1'b0; in_valid = 1'b0;
  endtask

  task automatic send_bits(logic [31:0] val, int n);
    for (int i = n - 1; i >= 0; i--) beat(1'b0, 1'b0, 1'b1, {3'b000, val[i]});
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0; data = 4'h0;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 231 on the mod-3 bit stream
    beat(1, 0, 0, 0);
    send_bits(32'd231, 8);
    beat(0, 1, 0, 0);
    chk("d231.res", 32'(res_a), 0);
    chk("d231.div", 32'(div_a), 1);
    chk("d231.cnt", 32'(cnt_a), 8);

    // 232 with gaps, last bit together with finish
    beat(1, 0, 0, 0);
    for (int i = 7; i >= 1; i--) begin
      beat(0, 0, 1, {3'b000, 1'(8'd232 >> i)});
      beat(0, 0, 0, 4'hF);
    end
    beat(0, 1, 1, 4'h0);
    chk("d232.res", 32'(res_a), 1);
    chk("d232.div", 32'(div_a), 0);
    chk("d232.cnt", 32'(cnt_a), 8);

    // hex digits E,7 -> 231 mod 5
    beat(1, 0, 0, 0);
    beat(0, 0, 1, 4'hE);
    beat(0, 0, 1, 4'h7);
    beat(0, 1, 0, 0);
    chk("hex.res", 32'(res_b), 1);
    chk("hex.cnt", 32'(cnt_b), 2);

    // base-4 digits 3333 -> 255 mod 7
    beat(1, 0, 0, 0);
    repeat (4) beat(0, 0, 1, 4'h3);
    beat(0, 1, 0, 0);
    chk("b4.res", 32'(res_c), 3);

    // restart mid-frame with a simultaneous first digit
    beat(1, 0, 0, 0);
    send_bits(32'hF, 4);
    beat(1, 0, 1, 4'h0);
    send_bits(32'b0000101, 7);
    beat(0, 1, 0, 0);
    chk("rst.res", 32'(res_a), 2);
    chk("rst.cnt", 32'(cnt_a), 8);

    // asynchronous reset mid-frame
    beat(1, 0, 0, 0);
    send_bits(32'b101, 3);
    #2;
    rst_n = 1'b0;
    #1;
    open = 1'b0; ov_exp = 1'b0; q.delete();
    for (int k = 0; k < 4; k++) begin
      last_res[k] = 0; last_cnt[k] = 0; last_div[k] = 1'b0;
    end
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    beat(0, 1, 0, 0);
    beat(1, 0, 0, 0);
    send_bits(32'd6, 3);
    beat(0, 1, 0, 0);
    chk("six.res", 32'(res_a), 0);
    chk("six.div", 32'(div_a), 1);

    // empty frame, then counter saturation on the 2-bit counter
    beat(1, 0, 0, 0);
    beat(0, 1, 0, 0);
    chk("empty.res", 32'(res_b), 0);
    chk("empty.div", 32'(div_b), 1);
    chk("empty.cnt", 32'(cnt_b), 0);
    beat(1, 0, 0, 0);
    repeat (5) beat(0, 0, 1, 4'(($urandom)));
    beat(0, 1, 0, 0);
    chk("sat.cnt", 32'(cnt_d), 3);

    // random frames with gaps, restarts, and stray finish/valid while idle
    repeat (150) begin
      repeat ($urandom_range(0, 2)) beat(0, 1'($urandom), 1'($urandom), 4'($urandom));
      beat(1, 0, 1'($urandom), 4'($urandom));
      repeat ($urandom_range(0, 10)) begin
        if ($urandom_range(0, 15) == 0)
          beat(1, 1'($urandom), 1'($urandom), 4'($urandom));
        else
          beat(0, 0, ($urandom_range(0, 3) != 0), 4'($urandom));
      end
      beat(0, 1, 1'($urandom), 4'($urandom));
    end
    beat(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/mod_n_stream.md
Name: mod_n_stream

Overview:
- Serial residue calculator: computes (frame value mod MOD) on an MSB-first digit stream framed by start/finish pulses.
- Parametrised successor to the single-bit mod-3 checker: modulus, digit width and frame-length counter are configurable.
- Adds a valid handshake on input, a registered result/valid pulse and divisibility flag.
- Sits between a serial receiver/bit source and checksum/validation logic.

Parameters:
- MOD, 3, modulus; legal range 2..2^RES_W.
- RES_W, 2, residue width; must satisfy 2^RES_W >= MOD.
- DIGIT_W, 1, bits accepted per valid beat (MSB of in_data is most significant).
- CNT_W, 8, width of the beat counter; counter saturates at 2^CNT_W-1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; opens a new frame
- finish  in  1  one-cycle pulse; closes the frame
- in_valid  in  1  in_data carries a digit this cycle
- in_data  in  DIGIT_W  digit, MSB-first within the frame
- busy  out  1  frame open (state ACC)
- residue  out  RES_W  result of last completed frame
- divisible  out  1  residue == 0 for last completed frame
- out_valid  out  1  one-cycle pulse when residue/divisible/beat_cnt update
- beat_cnt  out  CNT_W  number of accepted digits in last completed frame

Behaviour:
- Reset (async, rst_n=0): state IDLE; internal accumulator r=0, counter=0; busy=0, residue=0, divisible=0, out_valid=0, beat_cnt=0. Reset mid-frame discards the frame; no out_valid is produced.
- Arithmetic: per accepted digit, r_next = (r*2^DIGIT_W + in_data) mod MOD.
  - Implemented as DIGIT_W unrolled single-bit steps t = 2*t + bit, each followed by a conditional subtract of MOD (t < 2*MOD always holds).
  - Single-cycle, no division operator.
- States:
  - IDLE:
    - start=1 -> ACC, r=0, counter=0.
    - If in_valid=1 in the same cycle, that digit is the first digit: r = in_data mod MOD, counter=1.
    - finish and in_valid alone are ignored.
  - ACC:
    - in_valid=1 -> update r, counter+1 (saturating).
    - finish=1 -> IDLE. On that edge: residue <= final r (including any digit with in_valid in the same cycle), divisible <= (final r==0), beat_cnt <= final counter, out_valid <= 1 for exactly one cycle.
    - start=1 (with or without finish) -> restart: r/counter cleared (or loaded from a simultaneous digit as in IDLE), stay in ACC, no out_valid. start has priority over finish.
- busy=1 exactly while in ACC (registered; rises the cycle after start).
- Empty frame (start then finish with no digits): residue=0, divisible=1, beat_cnt=0, out_valid pulses.
- Gaps (in_valid=0 cycles inside a frame) do not change r or counter.
- residue/divisible/beat_cnt hold between frames; change only on out_valid.
- Latency: result valid on the clock edge that samples finish (out_valid high the following cycle).

Test Plan:
- MOD=3, DIGIT_W=1: start, bits of 231 (11100111) one per cycle, finish -> out_valid one cycle, residue=0, divisible=1, beat_cnt=8.
- MOD=3, DIGIT_W=1: frame 232 with in_valid gaps between bits; last bit driven in the same cycle as finish -> residue=1, divisible=0, beat_cnt=8.
- MOD=5, DIGIT_W=4: digits 0xE, 0x7 (231) -> residue=1, beat_cnt=2. MOD=7, DIGIT_W=2: digits 3,3,3,3 (255) -> residue=3.
- MOD=3: start, 4 bits 1111, second start with first digit 0, then bits 0000101, finish -> one out_valid only, residue=2, beat_cnt=8.
- rst_n pulsed low after 3 bits of a frame -> all outputs 0 immediately (asynchronously); no out_valid. A later finish alone is ignored; a subsequent full frame of 6 -> residue=0.
- Empty frame (start, finish next cycle) -> residue=0, divisible=1, beat_cnt=0. CNT_W=2 with 5 digits -> beat_cnt=3 (saturated).
